ram_axil_bridge: RTL and testbench

//  AXI4-Lite slave that initiates accesses on the single-port, byte-enabled, word-aligned RAM port.
//  It sits between the cache's AXI-Lite fabric and the data RAM, and drives addr/wen/ben/wdata.
//  It absorbs the RAM's registered read latency.
//  One transaction in flight; reads and writes are arbitrated with alternating priority.

---
 rtl/ram_axil_pkg.sv | 16 +
 rtl/ram_axil_bridge.sv | 171 +++++++++++++++++
 tb/tb_ram_axil_bridge.sv | 569 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_axil_pkg.sv
// Shared types and response codes for the AXI4-Lite to RAM bridge.
// Imported by ram_axil_bridge.
package ram_axil_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WRESP,
        RD,
        RRESP
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/ram_axil_bridge.sv
// AXI4-Lite slave driving a byte-enabled, word-aligned, registered-read RAM.
// Optional out-of-range/misaligned SLVERR responses under RAM_AXIL_ERR_RESP_EN.
module ram_axil_bridge
    import ram_axil_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH      = 32,
    parameter int MEM_ADDR_WIDTH      = 7,
    parameter int MEM_DATA_WIDTH      = 32,
    parameter int MEM_DATA_SIZE_BYTES = 4,
    parameter int RAM_RD_LATENCY      = 1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [AXI_ADDR_WIDTH-1:0]      s_awaddr,
    input  logic                           s_awvalid,
    output logic                           s_awready,
    input  logic [MEM_DATA_WIDTH-1:0]      s_wdata,
    input  logic [MEM_DATA_SIZE_BYTES-1:0] s_wstrb,
    input  logic                           s_wvalid,
    output logic                           s_wready,
    output logic [1:0]                     s_bresp,
    output logic                           s_bvalid,
    input  logic                           s_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]      s_araddr,
    input  logic                           s_arvalid,
    output logic                           s_arready,
    output logic [MEM_DATA_WIDTH-1:0]      s_rdata,
    output logic [1:0]                     s_rresp,
    output logic                           s_rvalid,
    input  logic                           s_rready,
    output logic [MEM_ADDR_WIDTH-1:0]      o_addr,
    output logic                           o_wen,
    output logic [MEM_DATA_SIZE_BYTES-1:0] o_ben,
    output logic [MEM_DATA_WIDTH-1:0]      o_write_data,
    input  logic [MEM_DATA_WIDTH-1:0]      i_read_data
);

    localparam int CNT_W =
        (RAM_RD_LATENCY < 2) ? 1 : $clog2(RAM_RD_LATENCY + 1);

    state_t                           state;
    logic                             prio_wr;
    logic [CNT_W-1:0]                 rd_cnt;
    logic                             err_q;
    logic [MEM_ADDR_WIDTH-1:0]        addr_q;
    logic [MEM_DATA_WIDTH-1:0]        data_q;
    logic [MEM_DATA_SIZE_BYTES-1:0]   strb_q;
    logic [MEM_DATA_WIDTH-1:0]        rdata_q;
    logic [1:0]                       bresp_q;
    logic [1:0]                       rresp_q;

    logic idle;
    logic wr_elig;
    logic rd_elig;
    logic pick_wr;
    logic acc_wr;
    logic acc_rd;
    logic aw_err;
    logic ar_err;
    logic wr_live;
    logic [MEM_ADDR_WIDTH-1:0] aw_word;
    logic [MEM_ADDR_WIDTH-1:0] ar_word;
    logic unused_addr;

    assign idle    = (state == IDLE);
    assign wr_elig = s_awvalid && s_wvalid;
    assign rd_elig = s_arvalid;
    assign pick_wr = wr_elig && (prio_wr || !rd_elig);

    // Gated by reset_n so the readys read 0 while reset is held.
    assign acc_wr = reset_n && idle && pick_wr;
    assign acc_rd = reset_n && idle && rd_elig && !pick_wr;

    assign aw_word = {s_awaddr[MEM_ADDR_WIDTH-1:2], 2'b00};
    assign ar_word = {s_araddr[MEM_ADDR_WIDTH-1:2], 2'b00};

`ifdef RAM_AXIL_ERR_RESP_EN
    assign aw_err = (|s_awaddr[AXI_ADDR_WIDTH-1:MEM_ADDR_WIDTH])
                 || (|s_awaddr[1:0]);
    assign ar_err = (|s_araddr[AXI_ADDR_WIDTH-1:MEM_ADDR_WIDTH])
                 || (|s_araddr[1:0]);
`else
    assign aw_err = 1'b0;
    assign ar_err = 1'b0;
`endif

    assign unused_addr = ^{s_awaddr[AXI_ADDR_WIDTH-1:MEM_ADDR_WIDTH],
                           s_awaddr[1:0],
                           s_araddr[AXI_ADDR_WIDTH-1:MEM_ADDR_WIDTH],
                           s_araddr[1:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            prio_wr <= 1'b1;
            rd_cnt  <= '0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            rdata_q <= '0;
            bresp_q <= RESP_OKAY;
            rresp_q <= RESP_OKAY;
        end else begin
            unique case (state)
                IDLE: begin
                    if (acc_wr) begin
                        state   <= WR;
                        prio_wr <= ~prio_wr;
                        addr_q  <= aw_word;
                        data_q  <= s_wdata;
                        strb_q  <= s_wstrb;
                        err_q   <= aw_err;
                    end else if (acc_rd) begin
                        prio_wr <= ~prio_wr;
                        addr_q  <= ar_word;
                        rd_cnt  <= CNT_W'(RAM_RD_LATENCY);
                        // Bad reads skip the RAM and answer at once.
                        if (ar_err) begin
                            state   <= RRESP;
                            rdata_q <= '0;
                            rresp_q <= RESP_SLVERR;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                WR: begin
                    state   <= WRESP;
                    bresp_q <= err_q ? RESP_SLVERR : RESP_OKAY;
                end
                WRESP: begin
                    if (s_bready) begin
                        state <= IDLE;
                    end
                end
                RD: begin
                    if (rd_cnt == '0) begin
                        state   <= RRESP;
                        rdata_q <= i_read_data;
                        rresp_q <= RESP_OKAY;
                    end else begin
                        rd_cnt <= rd_cnt - CNT_W'(1);
                    end
                end
                RRESP: begin
                    if (s_rready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign wr_live = (state == WR) && !err_q;

    assign s_awready    = acc_wr;
    assign s_wready     = acc_wr;
    assign s_arready    = acc_rd;
    assign s_bvalid     = (state == WRESP);
    assign s_bresp      = bresp_q;
    assign s_rvalid     = (state == RRESP);
    assign s_rresp      = rresp_q;
    assign s_rdata      = rdata_q;
    assign o_addr       = addr_q;
    assign o_wen        = wr_live;
    assign o_ben        = wr_live ? strb_q : '0;
    assign o_write_data = data_q;

endmodule

// File: tb/tb_ram_axil_bridge.sv
// Randomised self-checking bench for ram_axil_bridge against a word-array model.
// Expectations follow RAM_AXIL_ERR_RESP_EN when it is defined.
module tb_ram_axil_bridge;
    import ram_axil_pkg::*;

    localparam int LAT = 1;
`ifdef RAM_AXIL_ERR_RESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] s_awaddr = '0;
    logic        s_awvalid = 1'b0;
    logic        s_awready;
    logic [31:0] s_wdata = '0;
    logic [3:0]  s_wstrb = '0;
    logic        s_wvalid = 1'b0;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready = 1'b0;
    logic [31:0] s_araddr = '0;
    logic        s_arvalid = 1'b0;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready = 1'b0;
    logic [6:0]  o_addr;
    logic        o_wen;
    logic [3:0]  o_ben;
    logic [31:0] o_write_data;
    logic [31:0] i_read_data;

    int errors = 0;
    int checks = 0;
    int n_acc  = 0;
    logic [31:0] ref_mem [32];

    logic        ram_clr = 1'b1;
    logic [31:0] ram [32];
    logic [31:0] rd_q;

    always #5 clk = ~clk;

    ram_axil_bridge #(
        .AXI_ADDR_WIDTH(32),
        .MEM_ADDR_WIDTH(7),
        .MEM_DATA_WIDTH(32),
        .MEM_DATA_SIZE_BYTES(4),
        .RAM_RD_LATENCY(LAT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid),
        .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid),
        .s_rready(s_rready),
        .o_addr(o_addr), .o_wen(o_wen), .o_ben(o_ben),
        .o_write_data(o_write_data), .i_read_data(i_read_data)
    );

    // Registered-read RAM with one cycle of latency.
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 32; i++) ram[i] <= '0;
        end else if (o_wen) begin
            for (int i = 0; i < 4; i++)
                if (o_ben[i]) ram[o_addr[6:2]][8*i +: 8] <= o_write_data[8*i +: 8];
        end
        rd_q <= ram[o_addr[6:2]];
    end
    assign i_read_data = rd_q;

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] nw,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (s[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a % 32'd128) / 32'd4);
    endfunction

    function automatic bit is_err(input logic [31:0] a);
        return ERR_EN && ((a >= 32'd128) || (a % 32'd4 != 0));
    endfunction

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int bhold,
                            output logic [1:0] resp, output int blat,
                            output logic wen1, output logic [6:0] addr1,
                            output logic [3:0] ben1, output logic [31:0] wd1,
                            output bit stable, output bit ok);
        int t;
        ok = 1; stable = 1; resp = '0; blat = -1;
        wen1 = 0; addr1 = '0; ben1 = '0; wd1 = '0;
        @(negedge clk);
        s_awaddr = a; s_wdata = d; s_wstrb = s;
        s_awvalid = 1; s_wvalid = 1;
        #1;
        t = 0;
        while (!(s_awready && s_wready) && t < 50) begin
            @(negedge clk); #1; t++;
        end
        if (t >= 50) begin
            ok = 0; s_awvalid = 0; s_wvalid = 0;
            return;
        end
        n_acc++;
        @(negedge clk);
        s_awvalid = 0; s_wvalid = 0;
        wen1 = o_wen; addr1 = o_addr; ben1 = o_ben; wd1 = o_write_data;
        t = 1;
        while (!s_bvalid && t < 50) begin
            @(negedge clk); t++;
        end
        if (!s_bvalid) begin
            ok = 0;
            return;
        end
        blat = t;
        resp = s_bresp;
        repeat (bhold) begin
            @(negedge clk);
            if (!s_bvalid || s_bresp !== resp) stable = 0;
        end
        s_bready = 1;
        @(negedge clk);
        s_bready = 0;
    endtask

    task automatic do_read(input logic [31:0] a, input int rhold,
                           output logic [31:0] data, output logic [1:0] resp,
                           output int rlat, output bit stable, output bit ok);
        int t;
        ok = 1; stable = 1; data = '0; resp = '0; rlat = -1;
        @(negedge clk);
        s_araddr = a; s_arvalid = 1;
        #1;
        t = 0;
        while (!s_arready && t < 50) begin
            @(negedge clk); #1; t++;
        end
        if (t >= 50) begin
            ok = 0; s_arvalid = 0;
            return;
        end
        n_acc++;
        @(negedge clk);
        s_arvalid = 0;
        t = 1;
        while (!s_rvalid && t < 50) begin
            @(negedge clk); t++;
        end
        if (!s_rvalid) begin
            ok = 0;
            return;
        end
        rlat = t; data = s_rdata; resp = s_rresp;
        repeat (rhold) begin
            @(negedge clk);
            if (!s_rvalid || s_rdata !== data || s_rresp !== resp) stable = 0;
        end
        s_rready = 1;
        @(negedge clk);
        s_rready = 0;
    endtask

    task automatic test_reset;
        logic [95:0] outs;
        for (int i = 0; i < 32; i++) ref_mem[i] = '0;
        reset_n = 0; ram_clr = 1;
        s_awvalid = 1; s_wvalid = 1; s_arvalid = 1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({s_awready, s_wready, s_arready} !== 3'b000) begin
            errors++;
            $display("FAIL reset_readys got %b exp 000",
                     {s_awready, s_wready, s_arready});
        end
        s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
        @(negedge clk);
        reset_n = 1; ram_clr = 0; n_acc = 0;
        #1;
        outs = {s_bvalid, s_rvalid, s_bresp, s_rresp, s_rdata,
                o_addr, o_wen, o_ben, o_write_data, 16'h0};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0", outs);
        end
    endtask

    task automatic test_basic;
        logic [1:0] resp; int lat; logic wen1; logic [6:0] a1;
        logic [3:0] b1; logic [31:0] wd1; logic [31:0] rd; bit st; bit ok;
        do_write(32'h10, 32'hDEADBEEF, 4'hF, 0, resp, lat, wen1, a1, b1, wd1, st, ok);
        ref_mem[widx(32'h10)] = merge(ref_mem[widx(32'h10)], 32'hDEADBEEF, 4'hF);
        checks++;
        if (!ok || lat != 2) begin
            errors++; $display("FAIL basic_blat got %0d exp 2", lat);
        end
        checks++;
        if ({wen1, a1, b1, wd1} !== {1'b1, 7'h10, 4'hF, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL basic_ram_port got %b %h %h %h exp 1 10 f deadbeef",
                     wen1, a1, b1, wd1);
        end
        checks++;
        if (resp !== RESP_OKAY) begin
            errors++; $display("FAIL basic_bresp got %b exp 00", resp);
        end
        do_read(32'h10, 0, rd, resp, lat, st, ok);
        checks++;
        if (!ok || lat != 2 + LAT) begin
            errors++; $display("FAIL basic_rlat got %0d exp %0d", lat, 2 + LAT);
        end
        checks++;
        if (rd !== ref_mem[widx(32'h10)] || resp !== RESP_OKAY) begin
            errors++;
            $display("FAIL basic_rdata got %h/%b exp %h/00",
                     rd, resp, ref_mem[widx(32'h10)]);
        end
    endtask

    task automatic test_partial;
        logic [1:0] resp; int lat; logic wen1; logic [6:0] a1;
        logic [3:0] b1; logic [31:0] wd1; logic [31:0] rd; bit st; bit ok;
        do_write(32'h10, 32'h0000AB00, 4'h2, 1, resp, lat, wen1, a1, b1, wd1, st, ok);
        ref_mem[widx(32'h10)] = merge(ref_mem[widx(32'h10)], 32'h0000AB00, 4'h2);
        checks++;
        if (!ok || b1 !== 4'h2 || wen1 !== 1'b1 || resp !== RESP_OKAY || !st) begin
            errors++;
            $display("FAIL partial_ben got %h wen %b resp %b exp 2 1 00",
                     b1, wen1, resp);
        end
        do_read(32'h10, 0, rd, resp, lat, st, ok);
        checks++;
        if (!ok || rd !== 32'hDEADABEF) begin
            errors++; $display("FAIL partial_rdata got %h exp deadabef", rd);
        end
        do_write(32'h10, 32'h11223344, 4'h0, 0, resp, lat, wen1, a1, b1, wd1, st, ok);
        checks++;
        if (!ok || b1 !== 4'h0 || resp !== RESP_OKAY) begin
            errors++;
            $display("FAIL zero_strb got ben %h resp %b exp 0 00", b1, resp);
        end
        do_read(32'h10, 0, rd, resp, lat, st, ok);
        checks++;
        if (!ok || rd !== ref_mem[widx(32'h10)]) begin
            errors++;
            $display("FAIL zero_strb_rdata got %h exp %h", rd, ref_mem[widx(32'h10)]);
        end
    endtask

    task automatic tie_pair(input logic [31:0] a, input logic [31:0] d);
        bit exp_wr; int t; logic [31:0] old;
        old = ref_mem[widx(a)];
        exp_wr = (n_acc % 2 == 0);
        @(negedge clk);
        s_awaddr = a; s_wdata = d; s_wstrb = 4'hF;
        s_awvalid = 1; s_wvalid = 1;
        s_araddr = a; s_arvalid = 1;
        #1;
        checks++;
        if ({s_awready, s_arready} !== (exp_wr ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL tie_grant got aw%b ar%b exp_wr %0d",
                     s_awready, s_arready, exp_wr);
        end
        n_acc++;
        if (exp_wr) begin
            ref_mem[widx(a)] = d;
            @(negedge clk);
            s_awvalid = 0; s_wvalid = 0;
            t = 0;
            while (!s_bvalid && t < 20) begin
                @(negedge clk); t++;
            end
            s_bready = 1;
            @(negedge clk);
            s_bready = 0;
            #1;
            checks++;
            if (s_arready !== 1'b1) begin
                errors++; $display("FAIL tie_second_ar got %b exp 1", s_arready);
            end
            n_acc++;
            @(negedge clk);
            s_arvalid = 0;
            t = 0;
            while (!s_rvalid && t < 20) begin
                @(negedge clk); t++;
            end
            checks++;
            if (s_rvalid !== 1'b1 || s_rdata !== d) begin
                errors++;
                $display("FAIL tie_rdata_new got %b %h exp 1 %h", s_rvalid, s_rdata, d);
            end
            s_rready = 1;
            @(negedge clk);
            s_rready = 0;
        end else begin
            @(negedge clk);
            s_arvalid = 0;
            t = 0;
            while (!s_rvalid && t < 20) begin
                @(negedge clk); t++;
            end
            checks++;
            if (s_rvalid !== 1'b1 || s_rdata !== old) begin
                errors++;
                $display("FAIL tie_rdata_old got %b %h exp 1 %h", s_rvalid, s_rdata, old);
            end
            s_rready = 1;
            @(negedge clk);
            s_rready = 0;
            #1;
            checks++;
            if (s_awready !== 1'b1) begin
                errors++; $display("FAIL tie_second_aw got %b exp 1", s_awready);
            end
            n_acc++;
            ref_mem[widx(a)] = d;
            @(negedge clk);
            s_awvalid = 0; s_wvalid = 0;
            t = 0;
            while (!s_bvalid && t < 20) begin
                @(negedge clk); t++;
            end
            checks++;
            if (s_bvalid !== 1'b1 || s_bresp !== RESP_OKAY) begin
                errors++;
                $display("FAIL tie_bresp got %b %b exp 1 00", s_bvalid, s_bresp);
            end
            s_bready = 1;
            @(negedge clk);
            s_bready = 0;
        end
    endtask

    task automatic test_arbitration;
        logic [1:0] resp; int lat; logic wen1; logic [6:0] a1;
        logic [3:0] b1; logic [31:0] wd1; bit st; bit ok;
        @(negedge clk);
        reset_n = 0;
        @(negedge clk);
        reset_n = 1; n_acc = 0;
        tie_pair(32'h20, 32'hA5A5_0001);
        do_write(32'h24, 32'h0BAD_F00D, 4'hF, 0, resp, lat, wen1, a1, b1, wd1, st, ok);
        ref_mem[widx(32'h24)] = 32'h0BAD_F00D;
        tie_pair(32'h20, 32'h5A5A_0002);
    endtask

    task automatic test_back_pressure;
        logic [1:0] resp; int lat; logic wen1; logic [6:0] a1;
        logic [3:0] b1; logic [31:0] wd1; bit st; bit ok;
        bit hold_ok; bit no_ar; int t;
        do_write(32'h30, 32'h1357_9BDF, 4'hF, 0, resp, lat, wen1, a1, b1, wd1, st, ok);
        ref_mem[widx(32'h30)] = 32'h1357_9BDF;
        do_write(32'h34, 32'h2468_ACE0, 4'hF, 0, resp, lat, wen1, a1, b1, wd1, st, ok);
        ref_mem[widx(32'h34)] = 32'h2468_ACE0;
        @(negedge clk);
        s_araddr = 32'h30; s_arvalid = 1;
        #1;
        t = 0;
        while (!s_arready && t < 20) begin
            @(negedge clk); #1; t++;
        end
        n_acc++;
        @(negedge clk);
        s_arvalid = 0;
        t = 0;
        while (!s_rvalid && t < 20) begin
            @(negedge clk); t++;
        end
        s_araddr = 32'h34; s_arvalid = 1;
        hold_ok = 1; no_ar = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (!s_rvalid || s_rdata !== ref_mem[widx(32'h30)] || s_rresp !== RESP_OKAY)
                hold_ok = 0;
            if (s_arready) no_ar = 0;
            @(negedge clk);
        end
        checks++;
        if (!hold_ok) begin
            errors++;
            $display("FAIL hold_rdata got %b %h exp 1 %h",
                     s_rvalid, s_rdata, ref_mem[widx(32'h30)]);
        end
        s_rready = 1;
        #1;
        if (s_arready) no_ar = 0;
        checks++;
        if (!no_ar) begin
            errors++; $display("FAIL hold_no_ar got arready 1 exp 0");
        end
        @(negedge clk);
        s_rready = 0;
        #1;
        checks++;
        if (s_arready !== 1'b1) begin
            errors++; $display("FAIL hold_next_ar got %b exp 1", s_arready);
        end
        n_acc++;
        @(negedge clk);
        s_arvalid = 0;
        t = 0;
        while (!s_rvalid && t < 20) begin
            @(negedge clk); t++;
        end
        checks++;
        if (s_rvalid !== 1'b1 || s_rdata !== ref_mem[widx(32'h34)]) begin
            errors++;
            $display("FAIL hold_second got %b %h exp 1 %h",
                     s_rvalid, s_rdata, ref_mem[widx(32'h34)]);
        end
        s_rready = 1;
        @(negedge clk);
        s_rready = 0;
    endtask

    task automatic test_reset_mid_read;
        logic [92:0] outs; logic [31:0] rd; logic [1:0] resp;
        int lat; bit st; bit ok; bit quiet; int t;
        @(negedge clk);
        s_araddr = 32'h30; s_arvalid = 1;
        #1;
        t = 0;
        while (!s_arready && t < 20) begin
            @(negedge clk); #1; t++;
        end
        @(negedge clk);
        s_arvalid = 0;
        reset_n = 0;
        #1;
        outs = {s_awready, s_wready, s_arready, s_bvalid, s_rvalid,
                s_bresp, s_rresp, s_rdata, o_addr, o_wen, o_ben, o_write_data};
        checks++;
        if (outs !== '0) begin
            errors++; $display("FAIL reset_mid_outputs got %h exp 0", outs);
        end
        @(negedge clk);
        reset_n = 1; n_acc = 0;
        quiet = 1;
        repeat (4) begin
            @(negedge clk);
            if (s_rvalid || s_bvalid) quiet = 0;
        end
        checks++;
        if (!quiet) begin
            errors++; $display("FAIL reset_mid_no_resp got a response exp none");
        end
        do_read(32'h30, 2, rd, resp, lat, st, ok);
        checks++;
        if (!ok || rd !== ref_mem[widx(32'h30)] || resp !== RESP_OKAY
            || lat != 2 + LAT || !st) begin
            errors++;
            $display("FAIL reset_mid_fresh got %h/%b lat %0d exp %h/00 lat %0d",
                     rd, resp, lat, ref_mem[widx(32'h30)], 2 + LAT);
        end
    endtask

    task automatic test_addr_err;
        logic [1:0] resp; int lat; logic wen1; logic [6:0] a1;
        logic [3:0] b1; logic [31:0] wd1; logic [31:0] rd; bit st; bit ok;
        logic [1:0] exp_resp;
        exp_resp = ERR_EN ? RESP_SLVERR : RESP_OKAY;
        do_write(32'h82, 32'h1234_5678, 4'hF, 0, resp, lat, wen1, a1, b1, wd1, st, ok);
        if (!is_err(32'h82))
            ref_mem[widx(32'h82)] = 32'h1234_5678;
        checks++;
        if (!ok || resp !== exp_resp || wen1 !== !ERR_EN) begin
            errors++;
            $display("FAIL err_write got resp %b wen %b exp %b %b",
                     resp, wen1, exp_resp, !ERR_EN);
        end
        checks++;
        if (!ERR_EN && a1 !== 7'h00) begin
            errors++; $display("FAIL err_write_addr got %h exp 00", a1);
        end
        do_read(32'h82, 0, rd, resp, lat, st, ok);
        checks++;
        if (!ok || resp !== exp_resp
            || rd !== (ERR_EN ? 32'h0 : 32'h1234_5678)) begin
            errors++;
            $display("FAIL err_read got %h/%b exp %h/%b",
                     rd, resp, ERR_EN ? 32'h0 : 32'h1234_5678, exp_resp);
        end
    endtask

    task automatic test_random;
        logic [1:0] resp; int lat; logic wen1; logic [6:0] a1;
        logic [3:0] b1; logic [31:0] wd1; logic [31:0] rd; bit st; bit ok;
        logic [31:0] a; logic [31:0] d; logic [3:0] s; bit e;
        logic [31:0] exp_d;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 7) == 0) a = $urandom;
            else a = 32'($urandom_range(0, 31)) * 4;
            e = is_err(a);
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                do_write(a, d, s, $urandom_range(0, 2),
                         resp, lat, wen1, a1, b1, wd1, st, ok);
                checks++;
                if (!ok || lat != 2 || !st
                    || resp !== (e ? RESP_SLVERR : RESP_OKAY)
                    || wen1 !== !e) begin
                    errors++;
                    $display("FAIL rand_write a=%h got resp %b wen %b lat %0d exp %b %b 2",
                             a, resp, wen1, lat, e ? RESP_SLVERR : RESP_OKAY, !e);
                end
                if (!e) begin
                    checks++;
                    if (a1 !== 7'(widx(a) * 4) || b1 !== s || wd1 !== d) begin
                        errors++;
                        $display("FAIL rand_port a=%h got %h %h %h exp %h %h %h",
                                 a, a1, b1, wd1, 7'(widx(a) * 4), s, d);
                    end
                    ref_mem[widx(a)] = merge(ref_mem[widx(a)], d, s);
                end
            end else begin
                do_read(a, $urandom_range(0, 3), rd, resp, lat, st, ok);
                exp_d = e ? 32'h0 : ref_mem[widx(a)];
                checks++;
                if (!ok || !st || rd !== exp_d
                    || resp !== (e ? RESP_SLVERR : RESP_OKAY)
                    || (!e && lat != 2 + LAT)) begin
                    errors++;
                    $display("FAIL rand_read a=%h got %h/%b lat %0d exp %h/%b",
                             a, rd, resp, lat, exp_d, e ? RESP_SLVERR : RESP_OKAY);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_partial();
        test_arbitration();
        test_back_pressure();
        test_reset_mid_read();
        test_addr_err();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
